// File: rtl/reg_dump_reader.sv
// ============================================================================
// Module      : reg_dump_reader
// Description : Walks a register-file read port over [START_IDX..END_IDX]
//               and streams each word out through a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_dump_reader #(
  parameter int START_IDX = 0,
  parameter int END_IDX   = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic [4:0]  RA,
  input  logic [31:0] RD,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_idx,
  output logic        busy,
  output logic        done,
  output logic [31:0] checksum
);

  localparam logic [4:0] c_start_idx = 5'(START_IDX);
  localparam logic [4:0] c_end_idx   = 5'(END_IDX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  logic [4:0]  r_idx;
  logic        r_out_valid;
  logic [31:0] r_out_data;
  logic [4:0]  r_out_idx;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_checksum;

  // The read address comes straight from the index register, never from start.
  assign RA        = r_idx;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_idx   = r_out_idx;
  assign busy      = r_busy;
  assign done      = r_done;
  assign checksum  = r_checksum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= 5'd0;
      r_out_valid <= 1'b0;
      r_out_data  <= 32'd0;
      r_out_idx   <= 5'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_checksum  <= 32'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx      <= c_start_idx;
            r_checksum <= 32'd0;
            r_busy     <= 1'b1;
            r_state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (abort) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_out_data  <= RD;
            r_out_idx   <= r_idx;
            r_out_valid <= 1'b1;
            r_state     <= S_SEND;
          end
        end
        S_SEND: begin
          // Abort wins over a handshake in the same cycle; checksum keeps its partial value.
          if (abort) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end else if (r_out_valid && out_ready) begin
            r_checksum  <= r_checksum ^ r_out_data;
            r_out_valid <= 1'b0;
            if (r_idx == c_end_idx) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_idx   <= r_idx + 5'd1;
              r_state <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_dump_reader.sv
// ============================================================================
// Module      : tb_reg_dump_reader
// Description : Self-checking bench for reg_dump_reader (full window and a
//               single-register window instance).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_dump_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, ordy;
  logic [4:0]  ra;
  logic [31:0] rd;
  logic        ov;
  logic [31:0] od;
  logic [4:0]  oi;
  logic        busy, done;
  logic [31:0] cks;

  logic        b_start, b_abort, b_ordy;
  logic [4:0]  b_ra;
  logic [31:0] b_rd;
  logic        b_ov;
  logic [31:0] b_od;
  logic [4:0]  b_oi;
  logic        b_busy, b_done;
  logic [31:0] b_cks;

  logic [31:0] regs   [32];
  logic [31:0] b_regs [32];

  always #5 clk = ~clk;

  always_comb rd   = regs[ra];
  always_comb b_rd = b_regs[b_ra];

  reg_dump_reader dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .RA(ra), .RD(rd), .out_valid(ov), .out_ready(ordy),
    .out_data(od), .out_idx(oi), .busy(busy), .done(done), .checksum(cks)
  );

  reg_dump_reader #(.START_IDX(5), .END_IDX(5)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
    .RA(b_ra), .RD(b_rd), .out_valid(b_ov), .out_ready(b_ordy),
    .out_data(b_od), .out_idx(b_oi), .busy(b_busy), .done(b_done), .checksum(b_cks)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int n_words;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
  } word_t;
  word_t exp_q[$];

  typedef struct {
    int stall_idx;
    int stall_len;
    int abort_idx;
    bit rnd;
    int exp_words;
    bit exp_done;
    int exp_cycle;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted word must be the next expected one; held words must not move.
  logic        prev_hold = 1'b0;
  logic [31:0] prev_od;
  logic [4:0]  prev_oi;
  always @(negedge clk) begin
    if (!rst && prev_hold) begin
      check("hold_valid", 32'(ov), 32'd1);
      check("hold_data", od, prev_od);
      check("hold_idx", 32'(oi), 32'(prev_oi));
    end
    if (!rst && ov && ordy && !abort) begin
      n_words++;
      if (exp_q.size() == 0) begin
        check("extra_word_idx", 32'(oi), 32'hFFFF_FFFF);
      end else begin
        check("word_idx", 32'(oi), 32'(exp_q[0].idx));
        check("word_data", od, exp_q[0].data);
        void'(exp_q.pop_front());
      end
    end
    prev_hold = !rst && ov && !ordy && !abort;
    prev_od   = od;
    prev_oi   = oi;
  end

  task automatic fill_regs(input bit rnd);
    for (int i = 0; i < 32; i++)
      regs[i] = rnd ? ((i == 0) ? 32'd0 : $urandom) : (32'(i) * 32'h1111_1111);
  endtask

  task automatic run_dump(input vec_t v);
    int c, stalled, done_c;
    bit got_done, aborted;
    logic [31:0] exp_ck;
    fill_regs(v.rnd);
    exp_q.delete();
    exp_ck  = 32'd0;
    n_words = 0;
    for (int i = 0; i < v.exp_words; i++) begin
      exp_q.push_back('{idx: 5'(i), data: regs[i]});
      exp_ck ^= regs[i];
    end
    @(posedge clk); #1 start = 1'b1; ordy = 1'b1; abort = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("start_busy", 32'(busy), 32'd1);
    check("start_ra", 32'(ra), 32'd0);
    check("start_cks", cks, 32'd0);
    c = 0; stalled = 0; done_c = -1; got_done = 1'b0; aborted = 1'b0;
    while (!got_done && !aborted && c < 300) begin
      @(posedge clk); c++; #1;
      if (abort) begin
        abort = 1'b0; aborted = 1'b1;
      end else if (ov && int'(oi) == v.abort_idx) begin
        abort = 1'b1; ordy = 1'b1;
      end else if (ov && int'(oi) == v.stall_idx && stalled < v.stall_len) begin
        ordy = 1'b0; stalled++;
      end else begin
        ordy = 1'b1;
      end
      @(negedge clk);
      if (done) begin got_done = 1'b1; done_c = c; end
    end
    check("dump_ended", 32'(got_done | aborted), 32'd1);
    check("done_seen", 32'(got_done), 32'(v.exp_done));
    if (aborted) begin
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_valid", 32'(ov), 32'd0);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check("abort_no_done", 32'(done), 32'd0);
      end
    end
    if (got_done) begin
      check("done_cycle", 32'(done_c), 32'(v.exp_cycle));
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
      check("idle_after_done", 32'(busy), 32'd0);
    end
    check("checksum", cks, exp_ck);
    check("words_accepted", 32'(n_words), 32'(v.exp_words));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  vec_t vecs[5];
  int   guard;
  logic [31:0] ck_model;

  initial begin
    vecs[0] = '{stall_idx: -1, stall_len: 0, abort_idx: -1, rnd: 1'b0, exp_words: 32, exp_done: 1'b1, exp_cycle: 64};
    vecs[1] = '{stall_idx:  3, stall_len: 5, abort_idx: -1, rnd: 1'b0, exp_words: 32, exp_done: 1'b1, exp_cycle: 69};
    vecs[2] = '{stall_idx: -1, stall_len: 0, abort_idx: 10, rnd: 1'b0, exp_words: 10, exp_done: 1'b0, exp_cycle: 0};
    vecs[3] = '{stall_idx:  7, stall_len: 2, abort_idx: -1, rnd: 1'b1, exp_words: 32, exp_done: 1'b1, exp_cycle: 66};
    vecs[4] = '{stall_idx: -1, stall_len: 0, abort_idx: 31, rnd: 1'b1, exp_words: 31, exp_done: 1'b0, exp_cycle: 0};

    start = 1'b0; abort = 1'b0; ordy = 1'b1;
    b_start = 1'b0; b_abort = 1'b0; b_ordy = 1'b1;
    fill_regs(1'b0);
    for (int i = 0; i < 32; i++) b_regs[i] = $urandom;
    b_regs[5] = 32'hDEAD_BEEF;
    rst = 1'b1;
    #2;
    check("rst_ra", 32'(ra), 32'd0);
    check("rst_valid", 32'(ov), 32'd0);
    check("rst_data", od, 32'd0);
    check("rst_idx", 32'(oi), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cks", cks, 32'd0);
    check("rst_b_ra", 32'(b_ra), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int t = 0; t < 5; t++) run_dump(vecs[t]);

    // Asynchronous reset while a word is held in SEND.
    fill_regs(1'b0);
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back('{idx: 5'(i), data: regs[i]});
    @(posedge clk); #1 start = 1'b1; ordy = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!(ov && oi == 5'd4) && guard < 100);
    check("reach_idx4", 32'(oi), 32'd4);
    #2 rst = 1'b1;
    #1;
    check("arst_ra", 32'(ra), 32'd0);
    check("arst_valid", 32'(ov), 32'd0);
    check("arst_data", od, 32'd0);
    check("arst_idx", 32'(oi), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_cks", cks, 32'd0);
    #1 rst = 1'b0;
    exp_q.delete();
    run_dump(vecs[0]);

    // start held high through a whole dump.
    fill_regs(1'b0);
    exp_q.delete();
    ck_model = 32'd0;
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back('{idx: 5'(i), data: regs[i]});
      ck_model ^= regs[i];
    end
    for (int i = 0; i < 2; i++) exp_q.push_back('{idx: 5'(i), data: regs[i]});
    @(posedge clk); #1 start = 1'b1; ordy = 1'b1;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!done && guard < 200);
    check("held_done", 32'(done), 32'd1);
    check("held_cks", cks, ck_model);
    @(negedge clk);
    check("held_idle", 32'(busy), 32'd0);
    check("held_cks_kept", cks, ck_model);
    @(negedge clk);
    check("held_restart_busy", 32'(busy), 32'd1);
    check("held_restart_cks", cks, 32'd0);
    check("held_restart_ra", 32'(ra), 32'd0);
    guard = 0;
    do begin @(posedge clk); #1; guard++; end while (!(ov && oi == 5'd2) && guard < 50);
    abort = 1'b1; start = 1'b0;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("held_abort_busy", 32'(busy), 32'd0);
    check("held_abort_cks", cks, regs[0] ^ regs[1]);
    check("held_queue_empty", 32'(exp_q.size()), 32'd0);

    // Single-register window; abort during DONE must not disturb it.
    @(posedge clk); #1 b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    @(negedge clk);
    check("b_ra", 32'(b_ra), 32'd5);
    check("b_busy", 32'(b_busy), 32'd1);
    @(negedge clk);
    check("b_valid", 32'(b_ov), 32'd1);
    check("b_idx", 32'(b_oi), 32'd5);
    check("b_data", b_od, 32'hDEAD_BEEF);
    @(posedge clk); #1 b_abort = 1'b1;
    @(negedge clk);
    check("b_done", 32'(b_done), 32'd1);
    check("b_cks", b_cks, 32'hDEAD_BEEF);
    check("b_valid_clr", 32'(b_ov), 32'd0);
    @(posedge clk); #1 b_abort = 1'b0;
    @(negedge clk);
    check("b_done_pulse", 32'(b_done), 32'd0);
    check("b_idle", 32'(b_busy), 32'd0);
    check("b_cks_held", b_cks, 32'hDEAD_BEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_dump_reader.md
REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 SHALL have parameter START_IDX, default 0, first register index dumped.
REQ-002 SHALL have parameter END_IDX, default 31, last register index dumped; legal only if START_IDX <= END_IDX <= 31.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  dump request, sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  cancel the dump in progress.
REQ-007 SHALL have port RA  output  5  read address driven to a register-file read port.
REQ-008 SHALL have port RD  input  32  combinational read data returned for RA.
REQ-009 SHALL have port out_valid  output  1  out_data/out_idx hold a word.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the word.
REQ-011 SHALL have port out_data  output  32  dumped register value.
REQ-012 SHALL have port out_idx  output  5  index of the dumped register.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse at dump completion.
REQ-015 SHALL have port checksum  output  32  XOR of all words accepted in the current or last dump.

Function
REQ-016 SHALL implement the states IDLE, FETCH, SEND and DONE, held in a registered state variable.
REQ-017 IDLE: if start=1, SHALL set idx=START_IDX and checksum=0, then go to FETCH; otherwise SHALL stay in IDLE.
REQ-018 SHALL drive RA from the registered idx at all times, with no combinational path from start.
REQ-019 FETCH: SHALL register out_data<=RD and out_idx<=idx, set out_valid=1, then go to SEND.
REQ-020 SEND: while out_ready=0, SHALL hold out_valid, out_data and out_idx stable.
REQ-021 SEND: on out_valid&&out_ready, SHALL set checksum^=out_data and clear out_valid.
REQ-022 SEND: on that same handshake, SHALL go to DONE if idx==END_IDX, else set idx=idx+1 and go to FETCH.
REQ-023 DONE: SHALL assert done for exactly one cycle, then go to IDLE.
REQ-024 Latency: start accepted at edge N SHALL give FETCH in cycle N+1 and out_valid=1 from edge N+2.
REQ-025 With out_ready held at 1, SHALL emit one word every 2 cycles; a full 0..31 dump SHALL take 64 cycles plus 1 DONE cycle.
REQ-026 SHALL ignore start while busy=1.
REQ-027 abort=1 in FETCH or SEND SHALL clear out_valid and force IDLE at the next edge, with no done pulse and checksum left at its partial value.
REQ-028 abort SHALL take priority over a simultaneous handshake.
REQ-029 abort SHALL have no effect in IDLE or DONE.
REQ-030 idx SHALL never exceed END_IDX and SHALL never wrap.
REQ-031 Register writes landing during a dump SHALL be reflected only if they occur before that register's FETCH cycle; no snapshot consistency is provided.
REQ-032 checksum SHALL hold its value after DONE until the next accepted start.

Reset
REQ-033 On rst=1, regardless of clock, SHALL immediately force: state=IDLE, idx=0, RA=0, out_valid=0, out_data=0, out_idx=0, busy=0, done=0, checksum=0.
REQ-034 Reset asserted mid-dump SHALL discard the dump, with no done pulse; the first start after rst deasserts SHALL begin a fresh dump from START_IDX.

Verification
REQ-035 Full dump: regfile x_i=i*0x11111111 (x0=0), out_ready=1, pulse start -> 32 words, idx 0..31 in order, each out_data matching; done at cycle 65 after start; checksum = XOR of all values.
REQ-036 Backpressure: hold out_ready=0 for 5 cycles on word idx 3 -> out_valid/out_data/out_idx stable throughout; no word lost or duplicated.
REQ-037 Abort: assert abort together with out_ready in SEND for idx 10 -> IDLE next cycle, out_valid=0, no done, checksum = XOR of idx 0..9 only.
REQ-038 Single-register window: START_IDX=END_IDX=5, x5=0xDEADBEEF -> exactly one word (idx 5); done pulse; checksum=0xDEADBEEF.
REQ-039 Async reset mid-SEND (no clock edge) -> outputs immediately at reset values; a restart after rst deasserts begins again at idx 0.
REQ-040 start held high throughout a dump -> ignored while busy; a new dump starts on the edge after DONE, and checksum clears at that point.
